// File: rtl/rtc_alarm_ctrl.sv
// RTC alarm controller: edge-detects the RTC alarm, rings for a bounded
// time, supports a limited number of snoozes and counts missed alarms.
module rtc_alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm_in,
  input  logic       enable,
  input  logic       ack,
  input  logic       snooze_req,
  output logic       irq,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic [7:0] missed_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RING = 2'b01,
    S_SNZ  = 2'b10
  } st_e;

  localparam logic [15:0] RING_LD = 16'(RING_SEC);
  localparam logic [15:0] SNZ_LD  = 16'(SNOOZE_SEC);
  localparam logic [1:0]  SNZ_MAX = 2'(MAX_SNOOZE);

  st_e         state_q;
  logic        irq_q;
  logic        alarm_q;
  logic [15:0] tmr_q;
  logic [1:0]  snz_q;
  logic [7:0]  miss_q;

  logic ev;
  logic snz_ok;
  logic last_sec;

  assign ev       = alarm_in & ~alarm_q;
  assign snz_ok   = snooze_req & (snz_q < SNZ_MAX);
  assign last_sec = (tmr_q <= 16'd1);

  assign irq        = irq_q;
  assign state      = state_q;
  assign snooze_cnt = snz_q;
  assign missed_cnt = miss_q;

  // Alarm edge tracking, ring/snooze FSM, timer and counters.
  // alarm_q resets high so a level already present at release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      alarm_q <= 1'b1;
      tmr_q   <= 16'd0;
      snz_q   <= 2'd0;
      miss_q  <= 8'd0;
    end else begin
      alarm_q <= alarm_in;
      if (!enable) begin
        state_q <= S_IDLE;
        irq_q   <= 1'b0;
        tmr_q   <= 16'd0;
      end else if (ev) begin
        state_q <= S_RING;
        irq_q   <= 1'b1;
        tmr_q   <= RING_LD;
        snz_q   <= 2'd0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            irq_q <= 1'b0;
          end
          S_RING: begin
            if (ack) begin
              state_q <= S_IDLE;
              irq_q   <= 1'b0;
              tmr_q   <= 16'd0;
            end else if (snz_ok) begin
              state_q <= S_SNZ;
              irq_q   <= 1'b0;
              tmr_q   <= SNZ_LD;
              snz_q   <= snz_q + 2'd1;
            end else if (sec_tick) begin
              if (last_sec) begin
                state_q <= S_IDLE;
                irq_q   <= 1'b0;
                tmr_q   <= 16'd0;
                if (miss_q != 8'hFF)
                  miss_q <= miss_q + 8'd1;
              end else begin
                tmr_q <= tmr_q - 16'd1;
              end
            end
          end
          S_SNZ: begin
            if (ack) begin
              state_q <= S_IDLE;
              irq_q   <= 1'b0;
              tmr_q   <= 16'd0;
            end else if (sec_tick) begin
              if (last_sec) begin
                state_q <= S_RING;
                irq_q   <= 1'b1;
                tmr_q   <= RING_LD;
              end else begin
                tmr_q <= tmr_q - 16'd1;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            tmr_q   <= 16'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Bench for rtc_alarm_ctrl: vector table, corner sequences and random
// stimulus against a second-counting reference model.
module tb_rtc_alarm_ctrl;

  localparam int RING   = 3;
  localparam int SNOOZE = 2;
  localparam int MAXS   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       alarm_in = 1'b0;
  logic       enable = 1'b0;
  logic       ack = 1'b0;
  logic       snooze_req = 1'b0;
  logic       irq;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic [7:0] missed_cnt;

  rtc_alarm_ctrl #(
    .RING_SEC  (RING),
    .SNOOZE_SEC(SNOOZE),
    .MAX_SNOOZE(MAXS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .alarm_in  (alarm_in),
    .enable    (enable),
    .ack       (ack),
    .snooze_req(snooze_req),
    .irq       (irq),
    .state     (state),
    .snooze_cnt(snooze_cnt),
    .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: mode 0 idle, 1 ringing, 2 snoozed; rem = seconds left.
  int m_mode;
  int m_rem;
  int m_snz;
  int m_miss;
  bit m_prev;

  typedef struct {
    bit a, e, k, s, t;
    int st, irq, snz, miss;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_rem  = 0;
    m_snz  = 0;
    m_miss = 0;
    m_prev = 1'b1;
  endtask

  task automatic model_sec(bit a, bit e, bit k, bit s, bit t);
    bit fresh;
    fresh  = a && !m_prev;
    m_prev = a;
    if (!e) begin
      m_mode = 0;
    end else if (fresh) begin
      m_mode = 1;
      m_rem  = RING;
      m_snz  = 0;
    end else if (m_mode != 0) begin
      if (k) begin
        m_mode = 0;
      end else if (s && m_mode == 1 && m_snz < MAXS) begin
        m_mode = 2;
        m_rem  = SNOOZE;
        m_snz  = m_snz + 1;
      end else if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_mode == 1) begin
            m_mode = 0;
            if (m_miss < 255) m_miss = m_miss + 1;
          end else begin
            m_mode = 1;
            m_rem  = RING;
          end
        end
      end
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".state"}, int'(state), m_mode);
    chk({tag, ".irq"}, int'(irq), (m_mode == 1) ? 1 : 0);
    chk({tag, ".snz"}, int'(snooze_cnt), m_snz);
    chk({tag, ".miss"}, int'(missed_cnt), m_miss);
  endtask

  task automatic step(bit a, bit e, bit k, bit s, bit t, string tag);
    alarm_in   = a;
    enable     = e;
    ack        = k;
    snooze_req = s;
    sec_tick   = t;
    @(posedge clk);
    model_sec(a, e, k, s, t);
    #1;
    chk_model(tag);
  endtask

  task automatic add(bit a, bit e, bit k, bit s, bit t,
                     int st, int iq, int sn, int ms);
    vec_t v;
    v.a = a; v.e = e; v.k = k; v.s = s; v.t = t;
    v.st = st; v.irq = iq; v.snz = sn; v.miss = ms;
    tbl.push_back(v);
  endtask

  initial begin
    add(0,1,0,0,1, 0,0,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,1,0, 2,0,1,0);
    add(1,1,0,0,1, 2,0,1,0);
    add(1,1,0,0,1, 1,1,1,0);
    add(0,1,0,1,0, 2,0,2,0);
    add(0,1,0,0,1, 2,0,2,0);
    add(0,1,0,0,1, 1,1,2,0);
    add(0,1,0,1,0, 1,1,2,0);
    add(0,1,0,0,1, 1,1,2,0);
    add(0,1,0,0,1, 1,1,2,0);
    add(0,1,1,0,1, 0,0,2,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,1,0, 2,0,1,0);
    add(0,1,0,0,0, 2,0,1,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,0,0,1, 0,0,0,1);
    add(0,1,0,0,0, 0,0,0,1);
    add(1,1,0,0,0, 1,1,0,1);
    add(1,1,0,1,0, 2,0,1,1);
    add(1,1,0,0,1, 2,0,1,1);
    add(1,1,0,0,1, 1,1,1,1);
    add(1,1,1,1,0, 0,0,1,1);
    add(0,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0, 0,0,1,1);
    add(1,1,0,0,0, 0,0,1,1);
    add(0,1,0,0,0, 0,0,1,1);
    add(1,1,0,0,0, 1,1,0,1);
    add(1,0,0,0,0, 0,0,0,1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.irq", int'(irq), 0);
    chk("rst.snz", int'(snooze_cnt), 0);
    chk("rst.miss", int'(missed_cnt), 0);
    reset = 1'b0;

    // Held alarm level: one event, irq the next cycle.
    step(1, 1, 0, 0, 0, "hold0");
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 0, 0, "hold");
    chk("hold.state", int'(state), 0);
    step(0, 1, 0, 0, 0, "hold.fall");
    step(1, 1, 0, 0, 0, "hold.edge");
    chk("hold.irq", int'(irq), 1);
    for (int i = 0; i < 9; i++)
      step(1, 1, 0, 0, 0, "hold.lvl");
    chk("hold.lvl.state", int'(state), 1);
    step(1, 1, 1, 0, 0, "hold.ack");

    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].a, tbl[i].e, tbl[i].k, tbl[i].s, tbl[i].t, "vecm");
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("vec%0d.irq", i), int'(irq), tbl[i].irq);
      chk($sformatf("vec%0d.snz", i), int'(snooze_cnt), tbl[i].snz);
      chk($sformatf("vec%0d.miss", i), int'(missed_cnt), tbl[i].miss);
    end

    // 300 unacknowledged alarms saturate the missed counter.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 0, 0, "sat.edge");
      step(0, 1, 0, 0, 0, "sat.low");
      for (int j = 0; j < RING; j++)
        step(0, 1, 0, 0, 1, "sat.tick");
    end
    chk("sat.miss", int'(missed_cnt), 255);

    // Asynchronous reset while ringing with alarm held high.
    step(1, 1, 0, 0, 0, "ar.edge");
    chk("ar.irq_pre", int'(irq), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.state", int'(state), 0);
    chk("ar.irq", int'(irq), 0);
    chk("ar.miss", int'(missed_cnt), 0);
    chk("ar.snz", int'(snooze_cnt), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, 1, "ar.post");
    chk("ar.post.irq", int'(irq), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit a, e, k, s, t;
      a = ($urandom % 8 == 0) ? ~alarm_in : alarm_in;
      e = ($urandom % 20) != 0;
      k = ($urandom % 12) == 0;
      s = ($urandom % 6) == 0;
      t = ($urandom % 3) == 0;
      step(a, e, k, s, t, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_ctrl.md
RTC_ALARM_CTRL -- requirements
Module: rtc_alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60: ring duration in seconds, legal range 1..65535.
REQ-002 SHALL have parameter SNOOZE_SEC, default 300: snooze duration in seconds, legal range 1..65535.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event, legal range 1..3.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sec_tick, input, 1 bit: one-cycle strobe marking each RTC second boundary.
REQ-007 SHALL have port alarm_in, input, 1 bit: alarm level from the RTC, high for the whole matching second.
REQ-008 SHALL have port enable, input, 1 bit: alarm handling enable.
REQ-009 SHALL have port ack, input, 1 bit: processor dismiss pulse.
REQ-010 SHALL have port snooze_req, input, 1 bit: processor snooze pulse.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt to the processor, high while RINGING.
REQ-012 SHALL have port state, output, 2 bits: 00=IDLE, 01=RINGING, 10=SNOOZED.
REQ-013 SHALL have port snooze_cnt, output, 2 bits: snoozes used for the current event.
REQ-014 SHALL have port missed_cnt, output, 8 bits: alarms that timed out without ack.

Function
REQ-015 SHALL detect alarm events as a rising edge of alarm_in against a registered copy alarm_q; a level held high yields exactly one event.
REQ-016 SHALL implement FSM IDLE/RINGING/SNOOZED with a 16-bit down-counter tmr that decrements only on sec_tick.
REQ-017 IDLE: event with enable=1 SHALL go to RINGING next cycle, load tmr=RING_SEC, and clear snooze_cnt.
REQ-018 RINGING: ack SHALL go to IDLE.
REQ-019 RINGING: snooze_req with snooze_cnt<MAX_SNOOZE SHALL go to SNOOZED, load tmr=SNOOZE_SEC, and increment snooze_cnt.
REQ-020 RINGING: snooze_req with snooze_cnt==MAX_SNOOZE SHALL be ignored.
REQ-021 RINGING: a sec_tick with tmr==1 SHALL go to IDLE and increment missed_cnt, saturating at 255.
REQ-022 SNOOZED: a sec_tick with tmr==1 SHALL go to RINGING and load tmr=RING_SEC; ack SHALL cancel to IDLE.
REQ-023 SHALL treat a new event in RINGING or SNOOZED as a fresh alarm: go to or stay in RINGING, reload tmr=RING_SEC, and clear snooze_cnt.
REQ-024 SHALL apply this priority within one cycle: enable=0 > new event > ack > snooze_req > timer expiry.
REQ-025 SHALL, when ack coincides with expiry, leave missed_cnt unchanged.
REQ-026 SHALL, with enable=0, force IDLE next cycle, ignore events (alarm_q still tracks alarm_in), and leave missed_cnt and snooze_cnt unchanged.
REQ-027 SHALL ignore ack and snooze_req in IDLE, and snooze_req in SNOOZED.
REQ-028 SHALL drive irq from a register; it SHALL be high exactly in the cycles where state==RINGING, one cycle after the triggering edge is sampled.
REQ-029 SHALL decrement tmr by exactly 1 per sec_tick, never below 1 while the timer is active; sec_tick in IDLE SHALL have no effect.

Reset
REQ-030 SHALL, on reset assertion, immediately set state=IDLE, irq=0, tmr=0, snooze_cnt=0, missed_cnt=0, and alarm_q=1, so that alarm_in high at reset release produces no event.
REQ-031 SHALL, when reset is asserted mid-RINGING or mid-SNOOZED, abandon the event without incrementing missed_cnt.

Verification (bench parameters RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2)
REQ-032 SHALL cover: alarm_in 0->1 held 10 cycles, no sec_tick -> one event, irq=1 from next cycle, state=01, snooze_cnt=0.
REQ-033 SHALL cover: ringing, 3 sec_ticks, no ack -> IDLE after the 3rd tick, irq=0, missed_cnt=1; 300 such events -> missed_cnt=255.
REQ-034 SHALL cover: ringing, snooze_req -> SNOOZED, snooze_cnt=1, irq=0; 2 ticks -> RINGING; snooze_req -> snooze_cnt=2; after re-ring, snooze_req -> ignored, state stays 01.
REQ-035 SHALL cover: ringing, ack+snooze_req in the same cycle -> IDLE, snooze_cnt unchanged; ack+expiring tick in the same cycle -> IDLE, missed_cnt unchanged.
REQ-036 SHALL cover: SNOOZED with snooze_cnt=1, new alarm edge -> RINGING, tmr=3, snooze_cnt=0; separately, enable=0 during RINGING -> IDLE next cycle, edges ignored.
REQ-037 SHALL cover: reset pulsed mid-RINGING with alarm_in held high -> outputs cleared asynchronously; after release with alarm_in still high, no irq.
